// File: rtl/counter_uart_tx.sv
// counter_uart_tx: picks up the 9-bit prescaled counter value, which is
// asynchronous to clk, waits for it to settle, and sends every new value to
// the host as a 3-byte UART frame (SYNC_BYTE, {7'b0, v[8]}, v[7:0]).
// Each byte is sent as a start bit, 8 data bits LSB first and one stop bit.
// Optional feature macro: TX_PARITY_EN adds an even-parity bit to every
// byte, placed between data bit 7 and the stop bit.
module counter_uart_tx #(
  parameter int unsigned BAUD_DIV  = 104,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [8:0] data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic [8:0]  s1_q, s2_q, lastVal_q, pendVal_q;
  logic        pending_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] baudCnt_q, baudCnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [8:0]  frameVal_q, frameVal_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        frameDone_q, frameDone_d;

  logic        accept, consume, bitDone;
  logic [7:0]  curByte;
  logic [2:0]  nextBit;

  // A value counts as settled once two consecutive samples agree; it is
  // accepted only if it differs from the last accepted value.
  assign accept  = (s1_q == s2_q) && (s2_q != lastVal_q);
  assign consume = (state_q == ST_IDLE) && pending_q;
  assign bitDone = (baudCnt_q == BAUD_LAST);
  assign nextBit = bitIdx_q + 3'd1;

  // Two-stage sampler plus a one-deep pending slot that always holds the
  // newest accepted value; an accept in the same cycle as a consume wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lastVal_q <= '0;
      pendVal_q <= '0;
      pending_q <= 1'b0;
    end else begin
      s1_q <= data;
      s2_q <= s1_q;
      if (accept) begin
        lastVal_q <= s2_q;
        pendVal_q <= s2_q;
      end
      pending_q <= accept | (pending_q & ~consume);
    end
  end

  // Select the byte of the frame currently being shifted out.
  always_comb begin
    curByte = frameVal_q[7:0];
    case (byteIdx_q)
      2'd0:    curByte = SYNC_BYTE;
      2'd1:    curByte = {7'b0, frameVal_q[8]};
      default: curByte = frameVal_q[7:0];
    endcase
  end

  // Frame sequencer: the baud counter restarts on every bit boundary, and
  // tx is registered so each bit holds for exactly BAUD_DIV cycles.
  always_comb begin
    state_d     = state_q;
    bitIdx_d    = bitIdx_q;
    byteIdx_d   = byteIdx_q;
    frameVal_d  = frameVal_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    frameDone_d = 1'b0;
    if (state_q == ST_IDLE || bitDone) baudCnt_d = '0;
    else                               baudCnt_d = baudCnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d    = ST_START;
          frameVal_d = pendVal_q;
          byteIdx_d  = 2'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (bitDone) begin
          state_d  = ST_DATA;
          bitIdx_d = 3'd0;
          tx_d     = curByte[0];
        end
      end
      ST_DATA: begin
        if (bitDone) begin
          if (bitIdx_q != 3'd7) begin
            bitIdx_d = nextBit;
            tx_d     = curByte[nextBit];
          end else begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^curByte;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bitDone) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bitDone) begin
          if (byteIdx_q != 2'd2) begin
            byteIdx_d = byteIdx_q + 2'd1;
            state_d   = ST_START;
            tx_d      = 1'b0;
          end else begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            frameDone_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset drops the line to idle immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      baudCnt_q   <= '0;
      bitIdx_q    <= '0;
      byteIdx_q   <= '0;
      frameVal_q  <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baudCnt_q   <= baudCnt_d;
      bitIdx_q    <= bitIdx_d;
      byteIdx_q   <= byteIdx_d;
      frameVal_q  <= frameVal_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: doc/counter_uart_tx.md
Name: counter_uart_tx

Overview:
Downstream consumer of the prescaled 9-bit free-running counter value; ships it to the host PC over UART.
- Samples the counter bus in the fast system clock domain.
- Filters values that are still changing or metastable.
- On every new stable value, transmits a 3-byte frame (sync, high, low) at a fixed baud rate.
- Sits between the counter block and the board's FTDI TX pin.

Parameters:
BAUD_DIV, 104, system clock cycles per UART bit (12 MHz / 115200); legal range 2..65535.
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock (same clock that feeds the counter's prescaler)
rstn  input  1  asynchronous active-low reset
data  input  9  counter value; registered in the slow prescaled domain, so asynchronous to clk
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is on the line
frame_done  output  1  one-clk pulse when the last stop bit of a frame completes

Behaviour:
- Reset, async, while rstn=0:
  - tx=1, busy=0, frame_done=0.
  - State=IDLE, pending=0.
  - Sampler regs s1=s2=0, last_val=0, baud counter=0.
  - Takes effect immediately, including mid-frame; no partial byte resumes after release.
- Input filter:
  - s1<=data; s2<=s1 each clk.
  - Value is stable when s1==s2.
  - If stable and s2!=last_val: pending<=1, pend_val<=s2, last_val<=s2.
  - A value must persist 2 consecutive clk samples to be accepted; single-cycle glitches are ignored.
- Pending register:
  - Holds only the newest value; newer accepted values overwrite pend_val while a frame is in flight.
  - Cleared when IDLE consumes it.
  - Acceptance and consumption in the same cycle: pending stays 1 with the new value.
- Latency: data change at clk edge k produces tx falling (start bit) at edge k+4 when IDLE.
- Frame content, bytes in order:
  - SYNC_BYTE
  - {7'b0, v[8]}
  - v[7:0]
  - v = pend_val captured at frame start; later input changes never alter a frame in progress.
- Byte format: start bit 0, 8 data bits LSB first, 1 stop bit 1; no inter-byte gap.
- Bit timing: every bit, start and stop included, lasts exactly BAUD_DIV clk cycles. Baud counter restarts at every bit boundary, so there is no cumulative drift.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when pending=1: capture v, byte_idx=0, tx<=0, busy<=1.
  - START -> DATA after BAUD_DIV cycles; bit_idx=0.
  - DATA -> DATA while bit_idx<7; DATA -> STOP after bit 7.
  - STOP -> START if byte_idx<2 (byte_idx+1).
  - STOP -> IDLE if byte_idx==2: busy<=0, frame_done<=1 for one cycle, tx stays 1.
- Back-to-back frames: if pending=1 on return to IDLE, START begins the next clk. The minimum 1-cycle idle-high is permitted.
- busy is high from the cycle tx first goes low until the cycle frame_done pulses; both deassert/assert on the same edge.
- Wrap-around: counter roll from 0x1FF to 0x000 is a normal change and is sent as bytes A5, 00, 00.

Optional Feature:
TX_PARITY_EN
- Defined: each byte carries an even-parity bit (XOR of its 8 data bits) after bit 7 and before the stop bit. Adds state PARITY (DATA -> PARITY -> STOP), giving 11 bits per byte and 33*BAUD_DIV cycles per frame.
- Undefined: no PARITY state or logic; 10 bits per byte, 30*BAUD_DIV cycles per frame.

Test Plan:
(Bench uses BAUD_DIV=4, macro undefined unless noted.)
- Reset: hold rstn=0, toggle data -> tx=1, busy=0, frame_done=0 throughout; no activity after release while data stays 0.
- Single update: data 0 -> 0x0A5 -> tx falls 4 clk later; decoded bytes A5, 00, A5; busy high for exactly 120 clk; one frame_done pulse.
- MSB and glitch: data=0x1FF held -> bytes A5, 01, FF. Then data pulses to 0x100 for 1 clk and returns to 0x1FF -> no further frame.
- Overwrite: data 0x001, then 0x002 and 0x003 applied during that frame -> exactly two frames: value 0x001 then value 0x003, separated by at least 1 idle-high clk.
- Reset mid-frame: rstn low during a data bit -> tx=1 within the same cycle, busy=0. After release with data=0x007 -> one fresh complete frame A5, 00, 07.
- TX_PARITY_EN defined: data=0x003 -> bytes A5 (parity 0), 00 (parity 0), 03 (parity 0); data=0x001 -> last byte parity 1; frame length 132 clk.
